serial_parity_checker: RTL and testbench
========================================

// Module: serial_parity_checker
// PURPOSE
//  Bit-serial frame receiver that sits downstream of the 2-input XOR stage (s = a ^ b).
//  It folds each incoming data bit into a running XOR, then checks the trailing parity bit.
//  It captures WIDTH data bits (LSB first) plus one parity bit.
//  It presents the assembled word and a parity-error flag behind a valid/ack handshake.
// PARAMETERS
//  WIDTH  8  data bits per frame (>= 1)
//  ODD    0  0 = even parity expected, 1 = odd parity expected
// PORTS
//  clk         in   1      single clock, all state changes on rising edge
//  reset       in   1      synchronous, active-high; sampled on rising edge of clk
//  start       in   1      frame start request; honoured only in IDLE
//  bit_in      in   1      serial data/parity bit
//  bit_valid   in   1      bit_in is sampled on a cycle where bit_valid=1
//  data_out    out  WIDTH  assembled word; bit 0 = first received bit
//  parity_err  out  1      1 = received parity does not match the expected value
//  data_valid  out  1      data_out/parity_err valid; held until acked
//  data_ack    in   1      consumer accepts the result
//  busy        out  1      1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs are 0, including data_out and parity_err. Accumulator=0, bit count=0.
//  - FSM states: IDLE, DATA, PARITY, HOLD (2-bit encoding).
//  - IDLE:
//    - start=1 -> DATA. Clears accumulator, shift register and count.
//    - bit_valid in IDLE is ignored.
//  - DATA:
//    - Each cycle with bit_valid=1: shift reg[cnt]<=bit_in, acc<=acc^bit_in, cnt<=cnt+1.
//    - When the WIDTH-th bit is sampled -> PARITY on the next edge.
//    - Cycles with bit_valid=0 make no change (gaps are allowed, no timeout).
//  - PARITY:
//    - First cycle with bit_valid=1: parity_err<=acc^bit_in^ODD. data_out<=shift reg.
//    - Same edge goes to HOLD, and data_valid<=1.
//    - Latency: data_valid rises 1 cycle after the parity bit is sampled.
//  - HOLD:
//    - data_out, parity_err and data_valid stay stable until data_ack=1.
//    - data_ack=1 -> IDLE. data_valid falls on that edge. data_out and parity_err keep their last value.
//    - bit_valid in HOLD is ignored (bits dropped).
//  - start is ignored outside IDLE.
//    - This includes start arriving in the same cycle as data_ack in HOLD.
//    - Such a start is lost and must be reissued once in IDLE.
//  - data_ack outside HOLD is ignored.
//  - Reset mid-frame (any state): immediate return to IDLE with the reset values above.
//    Any partial frame is discarded.
//  - Width rules:
//    - cnt is $clog2(WIDTH+1) bits; it never wraps because the DATA exit occurs at cnt==WIDTH-1 with bit_valid=1.
//    - acc is 1 bit.
// STRUCTURE
//  - Shared package/header: state localparams S_IDLE=2'd0, S_DATA=2'd1, S_PARITY=2'd2, S_HOLD=2'd3.
//  - Sub-module parity_acc (1 bit, ports clk, reset, clr, en, d, q): q<=clr?0:(en?q^d:q).
//    - It is built around a primitive xor gate.
//    - The top level instantiates one parity_acc. The FSM, counter and shift register live in the top level.
// TESTING (WIDTH=8, ODD=0 unless noted)
//  1. Hold reset 2 cycles -> busy=0, data_valid=0, data_out=8'h00, parity_err=0.
//  2. start; bits 1,0,1,0,0,1,0,1 (8'hA5) then parity 0, all back-to-back
//     -> 1 cycle after the parity bit: data_valid=1, data_out=8'hA5, parity_err=0. Ack -> IDLE.
//  3. Same frame with parity 1 -> data_out=8'hA5, parity_err=1.
//  4. 8'h3C with bit_valid low 2 cycles between each bit; ack delayed 5 cycles
//     -> result 8'h3C, err=0.
//     - Outputs stable all 5 cycles.
//     - Extra bit_valid pulses in HOLD do not change the outputs.
//  5. Reset after 3 data bits -> IDLE next edge, busy=0.
//     - Then a fresh 8'hFF frame with parity 0 -> 8'hFF, err=0.
//     - Also: start+ack in the same HOLD cycle -> IDLE, busy=0.
//  6. ODD=1 instance: 8'h00 with parity 1 -> err=0. With parity 0 -> err=1.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// Shared state encoding and parity helper for the bit-serial frame receiver.
package serial_parity_checker_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_HOLD   = S_HOLD
  } state_e;

  // 1 when the folded data parity plus the received parity bit disagrees with the expected sense
  function automatic logic parity_mismatch(input logic acc, input logic par, input logic odd);
    return acc ^ par ^ odd;
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// One-bit running XOR accumulator with synchronous clear and enable.
module parity_acc
  import serial_parity_checker_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  logic fold_s;

  xor u_xor (fold_s, q, d);

  // Accumulator register: clear wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= fold_s;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: WIDTH data bits LSB first, one parity bit,
// result presented behind a valid/ack handshake.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             parity_err,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic           ODD_BIT  = (ODD != 0);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] data_out_r;
  logic             parity_err_r;
  logic             data_valid_r;
  logic             busy_r;
  logic             acc_s;
  logic             acc_clr_s;
  logic             acc_en_s;

  parity_acc u_parity_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .d     (bit_in),
    .q     (acc_s)
  );

  // Next-state and accumulator control
  always_comb begin
    next_s    = state_r;
    acc_clr_s = 1'b0;
    acc_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_s    = ST_DATA;
          acc_clr_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          acc_en_s = 1'b1;
          if (cnt_r == LAST_IDX) begin
            next_s = ST_PARITY;
          end else begin
            next_s = ST_DATA;
          end
        end else begin
          next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_valid) begin
          next_s = ST_HOLD;
        end else begin
          next_s = ST_PARITY;
        end
      end
      ST_HOLD: begin
        // A start arriving with the ack is deliberately dropped
        if (data_ack) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_HOLD;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State register, bit counter, shift register and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      shift_r      <= {WIDTH{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      parity_err_r <= 1'b0;
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= {WIDTH{1'b0}};
          end
        end
        ST_DATA: begin
          if (bit_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt_r == CW'(i)) begin
                shift_r[i] <= bit_in;
              end
            end
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            data_out_r   <= shift_r;
            parity_err_r <= parity_mismatch(acc_s, bit_in, ODD_BIT);
            data_valid_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (data_ack) begin
            data_valid_r <= 1'b0;
          end
        end
        default: begin
          data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_r;
  assign parity_err = parity_err_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed scoreboard bench: an even-parity and an odd-parity instance receive identical frames.
module tb_serial_parity_checker;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, bit_in, bit_valid, data_ack;
  logic [7:0] d0, d1;
  logic       e0, e1, v0, v1, b0, b1;

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       cur0, cur1;
  int         n_asserts = 0;
  int         n_fail    = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.WIDTH(8), .ODD(0)) u_dut_even (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(d0), .parity_err(e0), .data_valid(v0), .data_ack(data_ack), .busy(b0)
  );

  serial_parity_checker #(.WIDTH(8), .ODD(1)) u_dut_odd (
    .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(d1), .parity_err(e1), .data_valid(v1), .data_ack(data_ack), .busy(b1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_both(input string tag);
    check({tag, "_busy_even"}, {31'd0, b0}, 32'd0);
    check({tag, "_busy_odd"},  {31'd0, b1}, 32'd0);
    check({tag, "_valid_even"}, {31'd0, v0}, 32'd0);
    check({tag, "_valid_odd"},  {31'd0, v1}, 32'd0);
  endtask

  // Result must be visible one cycle after the parity bit; pop and compare both scoreboards
  task automatic expect_result(input string tag);
    check({tag, "_valid_even"}, {31'd0, v0}, 32'd1);
    check({tag, "_valid_odd"},  {31'd0, v1}, 32'd1);
    if (q0.size() == 0 || q1.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      cur0 = q0.pop_front();
      cur1 = q1.pop_front();
      check({tag, "_data_even"}, {24'd0, d0}, {24'd0, cur0.data});
      check({tag, "_err_even"},  {31'd0, e0}, {31'd0, cur0.err});
      check({tag, "_data_odd"},  {24'd0, d1}, {24'd0, cur1.data});
      check({tag, "_err_odd"},   {31'd0, e1}, {31'd0, cur1.err});
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] data, input logic p, input int gap);
    exp_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, {31'd0, b0}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i], gap);
    end
    check({tag, "_no_early_valid"}, {31'd0, v0}, 32'd0);
    e.data = data;
    e.err  = (^data) ^ p;
    q0.push_back(e);
    e.err  = (^data) ^ p ^ 1'b1;
    q1.push_back(e);
    send_bit(p, 0);
    expect_result(tag);
  endtask

  task automatic do_ack(input string tag);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check_idle_both({tag, "_ack"});
    check({tag, "_data_kept"}, {24'd0, d0}, {24'd0, cur0.data});
    check({tag, "_err_kept"},  {31'd0, e0}, {31'd0, cur0.err});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; data_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_both("reset");
    check("reset_data", {24'd0, d0}, 32'd0);
    check("reset_err",  {31'd0, e0}, 32'd0);
    reset = 1'b0;

    // bit_valid in IDLE is ignored
    send_bit(1'b1, 0);
    check_idle_both("idle_bits");

    send_frame("a5_p0", 8'hA5, 1'b0, 0);
    do_ack("a5_p0");
    send_frame("a5_p1", 8'hA5, 1'b1, 0);
    do_ack("a5_p1");

    send_frame("3c_gap", 8'h3C, 1'b0, 2);
    for (int k = 0; k < 5; k++) begin
      bit_in    = 1'b1;
      bit_valid = (k % 2 == 0);
      @(negedge clk);
      bit_valid = 1'b0;
      check("hold_data",  {24'd0, d0}, 32'h3C);
      check("hold_err",   {31'd0, e0}, 32'd0);
      check("hold_valid", {31'd0, v0}, 32'd1);
      check("hold_busy",  {31'd0, b0}, 32'd1);
    end
    do_ack("3c_gap");

    // Mid-frame reset discards the partial frame
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_both("midreset");
    check("midreset_data", {24'd0, d0}, 32'd0);
    check("midreset_err",  {31'd0, e0}, 32'd0);

    send_frame("ff_p0", 8'hFF, 1'b0, 0);
    do_ack("ff_p0");

    // start coincident with ack in HOLD is lost
    send_frame("5a_p0", 8'h5A, 1'b0, 1);
    start    = 1'b1;
    data_ack = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    data_ack = 1'b0;
    check_idle_both("start_ack");
    @(negedge clk);
    check_idle_both("start_ack_lost");

    send_frame("00_p1", 8'h00, 1'b1, 0);
    do_ack("00_p1");
    send_frame("00_p0", 8'h00, 1'b0, 0);
    do_ack("00_p0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
